// File: rtl/sd_log_writer.sv
// sd_log_writer: buffers a log byte stream and commits it to an SD card block by block over a
// strobe/we register bus. Define SD_LOG_WRITER_TIMEOUT_EN to bound the number of status polls.
module sd_log_writer #(
  parameter int unsigned BLOCK_BYTES   = 512,
  parameter int unsigned FIFO_DEPTH    = 16,
  parameter logic [5:0]  ADDR_TXDATA   = 6'h20,
  parameter logic [5:0]  ADDR_BLKADR   = 6'h04,
  parameter logic [5:0]  ADDR_CTRL     = 6'h01,
  parameter logic [5:0]  ADDR_STATUS   = 6'h02,
  parameter int unsigned TIMEOUT_POLLS = 65535
) (
  input  logic        clk_peri,
  input  logic        reset,
  input  logic [7:0]  in_data,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        start_i,
  input  logic [31:0] base_block_i,
  input  logic        flush_i,
  output logic [5:0]  sd_addr_o,
  output logic [7:0]  sd_dat_o,
  output logic        sd_strobe_o,
  output logic        sd_we_o,
  input  logic [7:0]  sd_dat_i,
  output logic        busy_o,
  output logic        error_o,
  output logic [15:0] blocks_written_o
);

  // state | meaning
  // IDLE  | waiting for start_i, input closed
  // FILL  | streaming FIFO bytes to TXDATA
  // PAD   | zero-filling the rest of a flushed block
  // ADDR  | writing the 4 block-number bytes, LSB first
  // CMD   | issuing the write-block command
  // POLL  | reading status every other cycle until not busy
  // NEXT  | advancing block number and committed count
  // ERR   | card error, bus silent until reset
  typedef enum logic [2:0] {
    S_IDLE, S_FILL, S_PAD, S_ADDR, S_CMD, S_POLL, S_NEXT, S_ERR
  } state_t;

  localparam int unsigned PW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = $clog2(BLOCK_BYTES + 1);
  localparam logic [CW-1:0] C_BLOCK = CW'(BLOCK_BYTES);

  state_t        r_state;
  logic [31:0]   r_blk;
  logic [CW-1:0] r_cnt;
  logic          r_flush;
  logic [1:0]    r_idx;
  logic          r_poll_ph;
  logic [15:0]   r_blocks;
  logic          r_strobe;
  logic          r_we;
  logic [5:0]    r_addr;
  logic [7:0]    r_dat;

`ifdef SD_LOG_WRITER_TIMEOUT_EN
  localparam int unsigned TW = (TIMEOUT_POLLS > 1) ? $clog2(TIMEOUT_POLLS) : 1;
  localparam logic [TW-1:0] C_TMO_LOAD = TW'(TIMEOUT_POLLS - 1);
  logic [TW-1:0] r_tmo;
`endif

  logic [7:0]  r_mem [FIFO_DEPTH];
  logic [PW:0] r_wr_ptr;
  logic [PW:0] r_rd_ptr;
  logic        w_empty;
  logic        w_full;
  logic        w_active;
  logic        w_pop;
  logic        w_push;
  logic [7:0]  w_fifo_dout;

  assign w_empty     = (r_wr_ptr == r_rd_ptr);
  assign w_full      = (r_wr_ptr[PW] != r_rd_ptr[PW]) && (r_wr_ptr[PW-1:0] == r_rd_ptr[PW-1:0]);
  assign w_active    = (r_state != S_IDLE) && (r_state != S_ERR);
  assign w_pop       = (r_state == S_FILL) && !w_empty;
  // A full FIFO still takes a byte in the same cycle one leaves it.
  assign in_ready    = w_active && (!w_full || w_pop);
  assign w_push      = in_valid && in_ready;
  assign w_fifo_dout = r_mem[r_rd_ptr[PW-1:0]];

  always_ff @(posedge clk_peri) begin
    if (w_push) r_mem[r_wr_ptr[PW-1:0]] <= in_data;
  end

  always_ff @(posedge clk_peri) begin
    if (!reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk_peri) begin
    if (!reset) begin
      r_state   <= S_IDLE;
      r_blk     <= '0;
      r_cnt     <= '0;
      r_flush   <= 1'b0;
      r_idx     <= '0;
      r_poll_ph <= 1'b0;
      r_blocks  <= '0;
      r_strobe  <= 1'b0;
      r_we      <= 1'b0;
      r_addr    <= '0;
      r_dat     <= '0;
`ifdef SD_LOG_WRITER_TIMEOUT_EN
      r_tmo     <= '0;
`endif
    end else begin
      // Bus outputs default to an idle, all-zero cycle.
      r_strobe <= 1'b0;
      r_we     <= 1'b0;
      r_addr   <= '0;
      r_dat    <= '0;
      case (r_state)
        S_IDLE: begin
          if (start_i) begin
            r_blk   <= base_block_i;
            r_cnt   <= '0;
            r_flush <= 1'b0;
            r_state <= S_FILL;
          end
        end
        S_FILL: begin
          if (w_pop) begin
            r_strobe <= 1'b1;
            r_we     <= 1'b1;
            r_addr   <= ADDR_TXDATA;
            r_dat    <= w_fifo_dout;
            r_cnt    <= r_cnt + CW'(1);
            if (r_cnt + CW'(1) == C_BLOCK) begin
              r_flush <= 1'b0;
              r_idx   <= '0;
              r_state <= S_ADDR;
            end else if (flush_i && (r_cnt != '0)) begin
              r_flush <= 1'b1;
            end
          end else if (r_flush) begin
            r_state <= S_PAD;
          end else if (flush_i && (r_cnt != '0)) begin
            r_flush <= 1'b1;
          end
        end
        S_PAD: begin
          r_strobe <= 1'b1;
          r_we     <= 1'b1;
          r_addr   <= ADDR_TXDATA;
          r_dat    <= 8'h00;
          r_cnt    <= r_cnt + CW'(1);
          if (r_cnt + CW'(1) == C_BLOCK) begin
            r_flush <= 1'b0;
            r_idx   <= '0;
            r_state <= S_ADDR;
          end
        end
        S_ADDR: begin
          r_strobe <= 1'b1;
          r_we     <= 1'b1;
          r_addr   <= ADDR_BLKADR + {4'b0000, r_idx};
          r_dat    <= r_blk[{r_idx, 3'b000} +: 8];
          r_idx    <= r_idx + 2'd1;
          if (r_idx == 2'd3) r_state <= S_CMD;
        end
        S_CMD: begin
          r_strobe  <= 1'b1;
          r_we      <= 1'b1;
          r_addr    <= ADDR_CTRL;
          r_dat     <= 8'h02;
          r_poll_ph <= 1'b0;
`ifdef SD_LOG_WRITER_TIMEOUT_EN
          r_tmo     <= C_TMO_LOAD;
`endif
          r_state   <= S_POLL;
        end
        S_POLL: begin
          // Phase 0 launches the read; phase 1 is the strobe cycle where status is valid.
          if (!r_poll_ph) begin
            r_strobe  <= 1'b1;
            r_addr    <= ADDR_STATUS;
            r_poll_ph <= 1'b1;
          end else begin
            r_poll_ph <= 1'b0;
            if (sd_dat_i[2:1] != 2'b00) begin
              r_state <= S_ERR;
            end else if (!sd_dat_i[0]) begin
              r_state <= S_NEXT;
            end
`ifdef SD_LOG_WRITER_TIMEOUT_EN
            else if (r_tmo == '0) begin
              r_state <= S_ERR;
            end else begin
              r_tmo <= r_tmo - TW'(1);
            end
`endif
          end
        end
        S_NEXT: begin
          r_blk    <= r_blk + 32'd1;
          r_blocks <= r_blocks + 16'd1;
          r_cnt    <= '0;
          r_state  <= S_FILL;
        end
        S_ERR: begin
          r_state <= S_ERR;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign sd_strobe_o      = r_strobe;
  assign sd_we_o          = r_we;
  assign sd_addr_o        = r_addr;
  assign sd_dat_o         = r_dat;
  assign busy_o           = w_active;
  assign error_o          = (r_state == S_ERR);
  assign blocks_written_o = r_blocks;

endmodule

// File: tb/tb_sd_log_writer.sv
// Bench for sd_log_writer: random byte streams against a block/bus-transaction reference model,
// with a scripted SD status responder.
module tb_sd_log_writer;

  localparam int BB = 512;
  localparam int TMO = 4;
  localparam logic [5:0] A_TX   = 6'h20;
  localparam logic [5:0] A_BLK  = 6'h04;
  localparam logic [5:0] A_CTRL = 6'h01;
  localparam logic [5:0] A_STAT = 6'h02;
`ifdef SD_LOG_WRITER_TIMEOUT_EN
  localparam int BUSY1 = 3;
`else
  localparam int BUSY1 = 5;
`endif
  localparam int STUCK = 1000;

  logic        clk_peri = 1'b0;
  logic        reset = 1'b0;
  logic [7:0]  in_data = '0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        start_i = 1'b0;
  logic [31:0] base_block_i = '0;
  logic        flush_i = 1'b0;
  logic [5:0]  sd_addr_o;
  logic [7:0]  sd_dat_o;
  logic        sd_strobe_o;
  logic        sd_we_o;
  logic [7:0]  sd_dat_i;
  logic        busy_o;
  logic        error_o;
  logic [15:0] blocks_written_o;

  always #5 clk_peri = ~clk_peri;

  sd_log_writer #(
    .BLOCK_BYTES(BB), .FIFO_DEPTH(16), .ADDR_TXDATA(A_TX), .ADDR_BLKADR(A_BLK),
    .ADDR_CTRL(A_CTRL), .ADDR_STATUS(A_STAT), .TIMEOUT_POLLS(TMO)
  ) dut (
    .clk_peri(clk_peri), .reset(reset), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .start_i(start_i), .base_block_i(base_block_i), .flush_i(flush_i),
    .sd_addr_o(sd_addr_o), .sd_dat_o(sd_dat_o), .sd_strobe_o(sd_strobe_o), .sd_we_o(sd_we_o),
    .sd_dat_i(sd_dat_i), .busy_o(busy_o), .error_o(error_o), .blocks_written_o(blocks_written_o)
  );

  typedef struct packed { logic [5:0] addr; logic we; logic [7:0] dat; logic first; } xact_t;
  typedef struct packed { logic [5:0] addr; logic we; logic [7:0] dat; logic [31:0] cyc; } obs_t;

  xact_t exp_q[$];
  obs_t  got_q[$];
  int n_exp = 0;
  int n_got = 0;
  int n_checks = 0;
  int n_errors = 0;
  int idle_viol = 0;
  logic [31:0] cyc = '0;
  logic [31:0] last_rd = '0;

  // status responder: busy_n busy replies after each write-block command, then final_st
  int busy_n = 0;
  logic [7:0] final_st = 8'h00;
  int poll_seen = 0;
  assign sd_dat_i = (poll_seen < busy_n) ? 8'h01 : final_st;

  always @(posedge clk_peri) begin
    cyc <= cyc + 1;
    if (sd_strobe_o && sd_we_o && sd_addr_o == A_CTRL) poll_seen <= 0;
    else if (sd_strobe_o && !sd_we_o && sd_addr_o == A_STAT) poll_seen <= poll_seen + 1;
  end

  always @(negedge clk_peri) begin
    if (sd_strobe_o) begin
      got_q.push_back(obs_t'{sd_addr_o, sd_we_o, sd_dat_o, cyc});
      n_got++;
    end else if (sd_we_o || sd_addr_o != 6'd0 || sd_dat_o != 8'd0) begin
      idle_viol++;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // reference model: byte stream -> blocks -> expected bus transactions
  logic [31:0] m_blk = '0;
  int          m_cnt = 0;
  logic [15:0] m_blocks = '0;
  bit          m_running = 0;

  task automatic m_push(input logic [5:0] a, input logic w, input logic [7:0] d, input logic f);
    exp_q.push_back(xact_t'{a, w, d, f});
    n_exp++;
  endtask

  task automatic m_commit();
    int reads;
    bit ok;
    for (int i = 0; i < 4; i++) m_push(A_BLK + 6'(i), 1'b1, m_blk[8*i +: 8], 1'b0);
    m_push(A_CTRL, 1'b1, 8'h02, 1'b0);
`ifdef SD_LOG_WRITER_TIMEOUT_EN
    if (busy_n >= TMO) begin reads = TMO; ok = 0; end else
`endif
    if (busy_n >= STUCK) begin reads = 12; ok = 0; end
    else begin reads = busy_n + 1; ok = (final_st[2:1] == 2'b00); end
    for (int i = 0; i < reads; i++) m_push(A_STAT, 1'b0, 8'h00, (i == 0));
    m_cnt = 0;
    if (ok) begin m_blk = m_blk + 1; m_blocks = m_blocks + 1; end
  endtask

  task automatic m_byte(input logic [7:0] b);
    m_push(A_TX, 1'b1, b, 1'b0);
    m_cnt++;
    if (m_cnt == BB) m_commit();
  endtask

  task automatic clear_model();
    exp_q.delete();
    got_q.delete();
    n_exp = n_got;
    m_running = 0;
    m_cnt = 0;
    m_blocks = '0;
    m_blk = '0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    int n;
    n = 0;
    @(negedge clk_peri);
    in_data = b;
    in_valid = 1'b1;
    #1;
    while (!in_ready && n < 4000) begin @(negedge clk_peri); #1; n++; end
    if (!in_ready) check("in_ready_wait", in_ready, 1);
    else m_byte(b);
    @(posedge clk_peri); #1;
    in_valid = 1'b0;
  endtask

  task automatic pulse_start(input logic [31:0] base);
    @(negedge clk_peri);
    start_i = 1'b1;
    base_block_i = base;
    @(negedge clk_peri);
    start_i = 1'b0;
    if (!m_running) begin m_blk = base; m_cnt = 0; m_running = 1; end
  endtask

  task automatic pulse_flush();
    @(negedge clk_peri);
    flush_i = 1'b1;
    @(negedge clk_peri);
    flush_i = 1'b0;
    if (m_cnt > 0) while (m_cnt != 0) m_byte(8'h00);
  endtask

  task automatic wait_drain();
    int k;
    k = 0;
    while (n_got != n_exp && k < 5000) begin @(posedge clk_peri); #1; k++; end
    check("drain", n_got, n_exp);
    repeat (3) @(posedge clk_peri);
    #1;
  endtask

  task automatic wait_blocks(input logic [15:0] n);
    int k;
    k = 0;
    while (blocks_written_o != n && k < 5000) begin @(posedge clk_peri); #1; k++; end
    check("wait_blocks", blocks_written_o, n);
  endtask

  task automatic wait_error();
    int k;
    k = 0;
    while (!error_o && k < 3000) begin @(posedge clk_peri); #1; k++; end
    check("wait_error", error_o, 1);
  endtask

  task automatic do_reset();
    @(negedge clk_peri);
    reset = 1'b0;
    in_valid = 1'b0;
    start_i = 1'b0;
    flush_i = 1'b0;
    @(posedge clk_peri); #1;
    check("rst_in_ready", in_ready, 0);
    check("rst_strobe", sd_strobe_o, 0);
    check("rst_we", sd_we_o, 0);
    check("rst_addr", sd_addr_o, 0);
    check("rst_dat", sd_dat_o, 0);
    check("rst_busy", busy_o, 0);
    check("rst_error", error_o, 0);
    check("rst_blocks", blocks_written_o, 0);
    repeat (2) @(negedge clk_peri);
    reset = 1'b1;
  endtask

  task automatic compare_q(input bit exact);
    xact_t e;
    obs_t g;
    if (exact) check("bus_len", got_q.size(), exp_q.size());
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      e = exp_q.pop_front();
      g = got_q.pop_front();
      check("bus_addr", g.addr, e.addr);
      check("bus_we", g.we, e.we);
      if (e.we) check("bus_dat", g.dat, e.dat);
      else begin
        if (!e.first) check("poll_gap", g.cyc - last_rd, 2);
        last_rd = g.cyc;
      end
    end
    exp_q.delete();
    got_q.delete();
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    int n;
    do_reset();
    clear_model();

    // full block of a counting pattern, status busy for several polls
    busy_n = BUSY1;
    final_st = 8'h00;
    pulse_start(32'h0000_0010);
    for (int i = 0; i < BB; i++) send_byte(8'(i));
    wait_blocks(1);
    compare_q(1);
    check("blocks_1", blocks_written_o, m_blocks);
    check("busy_fill", busy_o, 1);

    // start ignored while running; short block committed by flush; empty flush is a no-op
    busy_n = 0;
    pulse_start(32'hDEAD_BEEF);
    for (int i = 0; i < 3; i++) send_byte(8'($urandom));
    wait_drain();
    pulse_flush();
    wait_blocks(2);
    wait_drain();
    pulse_flush();
    repeat (40) @(negedge clk_peri);
    check("flush_empty_noop", n_got, n_exp);
    compare_q(1);
    check("blocks_2", blocks_written_o, m_blocks);

    // random stream across a block boundary with random gaps
    busy_n = $urandom_range(0, 3);
    for (int i = 0; i < 700; i++) begin
      send_byte(8'($urandom));
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(negedge clk_peri);
    end
    wait_drain();
    pulse_flush();
    wait_blocks(4);
    compare_q(1);
    check("blocks_4", blocks_written_o, m_blocks);

    // card reports an error on the second poll
    busy_n = 1;
    final_st = 8'h04;
    for (int i = 0; i < 5; i++) send_byte(8'($urandom));
    wait_drain();
    pulse_flush();
    wait_error();
    @(negedge clk_peri);
    in_valid = 1'b1;
    #1;
    check("err_in_ready", in_ready, 0);
    check("err_busy", busy_o, 0);
    repeat (30) @(negedge clk_peri);
    in_valid = 1'b0;
    check("err_no_strobe", n_got, n_exp);
    check("err_flag", error_o, 1);
    compare_q(1);
    check("err_blocks", blocks_written_o, m_blocks);

    do_reset();
    clear_model();

    // status stuck busy
    busy_n = STUCK * 100;
    final_st = 8'h00;
    pulse_start($urandom);
    for (int i = 0; i < 2; i++) send_byte(8'($urandom));
    wait_drain();
    pulse_flush();
`ifdef SD_LOG_WRITER_TIMEOUT_EN
    wait_error();
    repeat (20) @(negedge clk_peri);
    check("tmo_no_strobe", n_got, n_exp);
    compare_q(1);
`else
    k = 0;
    while (n_got < n_exp && k < 3000) begin @(posedge clk_peri); #1; k++; end
    check("stuck_polls", (n_got >= n_exp), 1);
    check("stuck_busy", busy_o, 1);
    check("stuck_no_err", error_o, 0);
    compare_q(0);
`endif

    do_reset();
    clear_model();

    // reset while the block number is being written
    busy_n = 0;
    final_st = 8'h00;
    pulse_start($urandom);
    for (int i = 0; i < BB; i++) send_byte(8'($urandom));
    k = 0;
    while (!(sd_strobe_o && sd_we_o && sd_addr_o == A_BLK + 6'd1) && k < 400) begin
      @(negedge clk_peri);
      k++;
    end
    check("saw_blkadr1", sd_addr_o, A_BLK + 6'd1);
    do_reset();
    check("rst_mid_len", got_q.size(), BB + 3);
    compare_q(0);
    clear_model();

    // clean block after the mid-block reset
    busy_n = 2;
    pulse_start($urandom);
    n = $urandom_range(50, 150);
    for (int i = 0; i < n; i++) send_byte(8'($urandom));
    wait_drain();
    pulse_flush();
    wait_blocks(1);
    compare_q(1);
    check("blocks_after_rst", blocks_written_o, m_blocks);

    check("idle_bus_zero", idle_viol, 0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/sd_log_writer.md
SD_LOG_WRITER -- requirements
Module: sd_log_writer

Interface
REQ-001 SHALL have parameter BLOCK_BYTES, default 512, meaning bytes per SD block.
REQ-002 SHALL have parameter FIFO_DEPTH, default 16 (power of two), meaning input byte FIFO entries.
REQ-003 SHALL have parameter ADDR_TXDATA, default 6'h20, meaning downstream TX-data register address.
REQ-004 SHALL have parameter ADDR_BLKADR, default 6'h04, meaning downstream block-address byte 0 address (bytes 1..3 at +1..+3).
REQ-005 SHALL have parameters ADDR_CTRL 6'h01 and ADDR_STATUS 6'h02, meaning downstream control and status register addresses.
REQ-006 SHALL have parameter TIMEOUT_POLLS, default 65535, meaning maximum status polls per block.
REQ-007 SHALL have port clk_peri, input, 1, the single clock; all logic on its rising edge.
REQ-008 SHALL have port reset, input, 1, synchronous active-low reset.
REQ-009 SHALL have ports in_data (input, 8), in_valid (input, 1) and in_ready (output, 1), forming the log byte stream.
REQ-010 SHALL have ports start_i (input, 1) and base_block_i (input, 32), meaning a start pulse and the first SD block number.
REQ-011 SHALL have port flush_i, input, 1, a pulse that zero-pads and commits the partial block.
REQ-012 SHALL have downstream ports sd_addr_o (output, 6), sd_dat_o (output, 8), sd_strobe_o (output, 1), sd_we_o (output, 1) and sd_dat_i (input, 8).
REQ-013 SHALL have ports busy_o (output, 1), error_o (output, 1) and blocks_written_o (output, 16).

Function
REQ-014 Input FIFO SHALL accept a byte when in_valid and in_ready; in_ready = FIFO not full and state != IDLE.
REQ-015 States SHALL be IDLE, FILL, PAD, ADDR, CMD, POLL, NEXT, ERR.
REQ-016 IDLE -> FILL on start_i: load block counter from base_block_i, clear byte count; start_i is ignored outside IDLE.
REQ-017 FILL: each cycle FIFO non-empty, pop one byte and issue one write (strobe=1, we=1, addr=ADDR_TXDATA); byte count +1.
REQ-018 FILL: byte count reaching BLOCK_BYTES -> ADDR; flush_i with count>0 sets a sticky flush flag; flag set and FIFO empty -> PAD; flush with count=0 is ignored.
REQ-019 PAD: write 8'h00 to ADDR_TXDATA one per cycle until count = BLOCK_BYTES, then ADDR; flush flag cleared.
REQ-020 ADDR: four consecutive writes of block counter bytes, LSB first, to ADDR_BLKADR+0..3; then CMD.
REQ-021 CMD: single write of 8'h02 (write-block) to ADDR_CTRL; then POLL.
REQ-022 POLL: read ADDR_STATUS (strobe=1, we=0) every second cycle; sd_dat_i sampled in the strobe cycle; bit0=1 means busy.
REQ-023 POLL: bit0=0 and bits[2:1]=0 -> NEXT; bits[2:1]!=0 -> ERR.
REQ-024 NEXT (one cycle): block counter +1 (32-bit wrap), blocks_written_o +1 (16-bit wrap), byte count cleared; -> FILL.
REQ-025 ERR: error_o=1, sd_strobe_o held 0, in_ready=0; exit only by reset.
REQ-026 sd_strobe_o SHALL be asserted for exactly one cycle per access; sd_addr_o/sd_dat_o/sd_we_o valid only while strobe is asserted, else 0.
REQ-027 busy_o=1 in every state except IDLE and ERR.
REQ-028 FIFO push and pop in the same cycle SHALL be permitted when full; occupancy is unchanged.
REQ-029 The FIFO SHALL keep accepting bytes during PAD/ADDR/CMD/POLL up to full.

Reset
REQ-030 With reset=0 at a clock edge, state SHALL become IDLE from any state, including mid-access.
REQ-031 Reset values SHALL be: in_ready=0, sd_strobe_o=0, sd_we_o=0, sd_addr_o=0, sd_dat_o=0, busy_o=0, error_o=0, blocks_written_o=0; FIFO emptied; counters 0.

Configuration
REQ-032 Macro SD_LOG_WRITER_TIMEOUT_EN defined: POLL counts reads and enters ERR after TIMEOUT_POLLS consecutive busy reads.
REQ-033 Macro SD_LOG_WRITER_TIMEOUT_EN undefined: no poll counter; POLL waits indefinitely.

Verification
REQ-034 start_i with base 0x00000010, then 512 bytes 0x00..0xFF repeating, status model idle -> 512 TXDATA writes in order, BLKADR writes 10,00,00,00, CTRL write 02, blocks_written_o=1.
REQ-035 3 bytes then flush_i -> 3 data writes, 509 writes of 00, one block committed; a second flush with count 0 produces no bus writes.
REQ-036 Status model returns 0x01 for 5 polls then 0x00 -> exactly 6 status reads, 2 cycles apart, then NEXT; block counter increments to 0x00000011.
REQ-037 Status model returns 0x04 -> ERR, error_o=1, in_ready=0, no further strobes until reset.
REQ-038 Timeout-enabled build with TIMEOUT_POLLS=4 and status stuck at 0x01 -> ERR after 4th read; disabled build polls indefinitely.
REQ-039 reset=0 asserted during ADDR -> next cycle IDLE, all outputs at reset values; a new start_i runs a clean block.
